branch_predictor_ctrl: RTL and testbench

//  Owns a table of ENTRIES 2-bit local predictors indexed by fetch PC; gives Fetch a

---
 rtl/branch_pred_pkg.sv | 32 +++
 rtl/branch_predictor_ctrl_local_predictor.sv | 25 ++
 rtl/branch_predictor_ctrl.sv | 101 ++++++++++
 tb/tb_branch_predictor_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings, the
// counter step function and the F->D->E pipeline payload.
package branch_pred_pkg;

    typedef logic [1:0] bp_state_t;

    localparam bp_state_t ST = 2'b11;
    localparam bp_state_t WT = 2'b10;
    localparam bp_state_t WU = 2'b01;
    localparam bp_state_t SU = 2'b00;

    // Widest index the pipeline payload can carry; the top uses the low INDEX_BITS.
    localparam int BP_IDX_W_MAX = 16;

    typedef struct packed {
        logic [BP_IDX_W_MAX-1:0] idx;
        logic                    pred;
        logic                    valid;
    } bp_pipe_t;

    function automatic bp_state_t bp_step(input bp_state_t state, input logic taken);
        bp_state_t result;
        result = state;
        if (taken && (state != ST)) begin
            result = state + 2'd1;
        end else if (!taken && (state != SU)) begin
            result = state - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_ctrl_local_predictor.sv
// One 2-bit saturating predictor entry; moves one step toward the
// resolved outcome when enabled, resets to weakly-untaken.
module local_predictor
    import branch_pred_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      enable,
    input  logic      outcome,
    output bp_state_t state
);

    bp_state_t state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= WU;
        end else if (enable) begin
            state_reg <= bp_step(state_reg, outcome);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Local 2-bit branch predictor table with F->D->E index/prediction tracking
// and mispredict flag. Define GSHARE_EN to XOR a global history into the index.
module branch_predictor_ctrl
    import branch_pred_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            BranchOpE,
    input  logic            PCSrcResE,
    output logic            PCSrcPredF,
    output logic            PCSrcPredE,
    output logic            MispredictE
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic                  update_en;
    bp_pipe_t              pipe_f;
    bp_pipe_t              pipe_d_reg;
    bp_pipe_t              pipe_e_reg;
    bp_state_t             table_state [ENTRIES];

    assign idx_e     = pipe_e_reg.idx[INDEX_BITS-1:0];
    assign update_en = BranchOpE & pipe_e_reg.valid & ~StallE;

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_reg <= '0;
        end else if (update_en) begin
            ghr_reg <= {ghr_reg[INDEX_BITS-2:0], PCSrcResE};
        end
    end

    assign idx_f = PCF[INDEX_BITS+1:2] ^ ghr_reg;
`else
    assign idx_f = PCF[INDEX_BITS+1:2];
`endif

    // Only the entry captured at fetch (carried in IdxE) is enabled.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            local_predictor u_entry (
                .clk     (clk),
                .reset   (reset),
                .enable  (update_en && (idx_e == INDEX_BITS'(gi))),
                .outcome (PCSrcResE),
                .state   (table_state[gi])
            );
        end
    endgenerate

    assign PCSrcPredF = table_state[idx_f][1];

    always_comb begin
        pipe_f       = '0;
        pipe_f.idx   = BP_IDX_W_MAX'(idx_f);
        pipe_f.pred  = PCSrcPredF;
        pipe_f.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_d_reg <= '0;
        end else if (FlushD) begin
            pipe_d_reg.valid <= 1'b0;
        end else if (!StallD) begin
            pipe_d_reg <= pipe_f;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_e_reg <= '0;
        end else if (FlushE) begin
            pipe_e_reg.valid <= 1'b0;
        end else if (!StallE) begin
            pipe_e_reg <= pipe_d_reg;
        end
    end

    assign PCSrcPredE  = pipe_e_reg.pred;
    assign MispredictE = BranchOpE & pipe_e_reg.valid & (pipe_e_reg.pred != PCSrcResE);

    // PC offset/upper bits and unused payload index bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{PCF[1:0], PCF >> (INDEX_BITS + 2), pipe_e_reg.idx >> INDEX_BITS};

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl with a scoreboard queue of expected
// outputs and a behavioural counter-table model.
module tb_branch_predictor_ctrl;

    localparam int IB = 6;
    localparam int XL = 32;
    localparam int NE = 2 ** IB;
`ifdef GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [XL-1:0] PCF;
    logic          StallD, FlushD, StallE, FlushE, BranchOpE, PCSrcResE;
    logic          PCSrcPredF, PCSrcPredE, MispredictE;

    always #5 clk = ~clk;

    branch_predictor_ctrl #(.INDEX_BITS(IB), .XLEN(XL)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .BranchOpE   (BranchOpE),
        .PCSrcResE   (PCSrcResE),
        .PCSrcPredF  (PCSrcPredF),
        .PCSrcPredE  (PCSrcPredE),
        .MispredictE (MispredictE)
    );

    typedef struct {
        string tag;
        logic  exp;
    } sb_t;

    sb_t           sb_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [1:0]    mdl [NE];
    logic [IB-1:0] ghr;

    function automatic logic [IB-1:0] m_idx(input logic [XL-1:0] pc);
        return pc[IB+1:2] ^ (GS ? ghr : '0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NE; i++) mdl[i] = 2'b01;
        ghr = '0;
    endtask

    task automatic m_update(input logic [IB-1:0] ix, input logic taken);
        if (taken && mdl[ix] != 2'b11) mdl[ix] = mdl[ix] + 2'd1;
        else if (!taken && mdl[ix] != 2'b00) mdl[ix] = mdl[ix] - 2'd1;
        ghr = {ghr[IB-2:0], taken};
    endtask

    task automatic push(input string tag, input logic exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic obs);
        sb_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%b expected=<queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [XL-1:0] pc);
        PCF = pc;
        push(tag, mdl[m_idx(pc)][1]);
        #1;
        pop_check(PCSrcPredF);
    endtask

    // Fetch a branch, walk it to E, resolve it and let the update land.
    task automatic send_branch(input logic [XL-1:0] pc, input logic taken);
        logic [IB-1:0] ix;
        logic          p;
        PCF       = pc;
        BranchOpE = 1'b0;
        ix        = m_idx(pc);
        p         = mdl[ix][1];
        push("br_predF", p);
        #4;
        pop_check(PCSrcPredF);
        cyc();
        cyc();
        BranchOpE = 1'b1;
        PCSrcResE = taken;
        push("br_predE", p);
        push("br_mispE", p != taken);
        #4;
        pop_check(PCSrcPredE);
        pop_check(MispredictE);
        cyc();
        BranchOpE = 1'b0;
        m_update(ix, taken);
    endtask

    logic [IB-1:0] ixa, ixb;
    logic          pa;

    initial begin
        reset = 1'b1; PCF = '0; StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
        BranchOpE = 0; PCSrcResE = 0;
        m_reset();
        #2;
        push("rst_predF", 1'b0); pop_check(PCSrcPredF);
        push("rst_predE", 1'b0); pop_check(PCSrcPredE);
        push("rst_mispE", 1'b0); pop_check(MispredictE);
        cyc();
        reset = 1'b0;
        cyc();

        // Every index reads weakly-untaken after reset.
        for (int i = 0; i < NE; i++) check_pc("init_read", XL'(i) << 2);
        cyc();

        // Two taken updates at 0x10, then neighbour untouched.
        send_branch(32'h10, 1'b1);
        check_pc("after_1st_taken", 32'h10);
        send_branch(32'h10, 1'b1);
        check_pc("after_2nd_taken", 32'h10);
        check_pc("neighbour_idx5", 32'h14);

        // Saturation both ways.
        for (int i = 0; i < 4; i++) send_branch(32'h10, 1'b1);
        send_branch(32'h10, 1'b0);
        check_pc("sat_st_to_wt", 32'h10);
        for (int i = 0; i < 3; i++) send_branch(32'h10, 1'b0);
        check_pc("sat_su", 32'h10);
        send_branch(32'h10, 1'b0);
        check_pc("sat_su_hold", 32'h10);

        // FlushE kills the E slot: no mispredict, no update.
        PCF = 32'h20;
        cyc();
        FlushE = 1'b1;
        cyc();
        FlushE = 1'b0; BranchOpE = 1'b1; PCSrcResE = 1'b1;
        push("flushE_misp", 1'b0);
        #4;
        pop_check(MispredictE);
        cyc();
        BranchOpE = 1'b0;
        check_pc("flushE_noupd", 32'h20);

        // StallE blocks the update.
        PCF = 32'h24;
        cyc();
        cyc();
        StallE = 1'b1; BranchOpE = 1'b1; PCSrcResE = 1'b1;
        cyc();
        StallE = 1'b0; BranchOpE = 1'b0;
        check_pc("stallE_noupd", 32'h24);
        cyc();

        // StallD holds IdxD/PredD while E keeps reloading from D.
        send_branch(32'h34, 1'b1);
        ixa = m_idx(32'h34);
        pa  = mdl[ixa][1];
        PCF = 32'h34;
        cyc();
        PCF = 32'h38; StallD = 1'b1;
        cyc();
        cyc();
        StallD = 1'b0; BranchOpE = 1'b1; PCSrcResE = 1'b0;
        push("stallD_predE", pa);
        push("stallD_mispE", pa != 1'b0);
        #4;
        pop_check(PCSrcPredE);
        pop_check(MispredictE);
        cyc();
        BranchOpE = 1'b0;
        m_update(ixa, 1'b0);
        check_pc("stallD_upd_idx", 32'h34);

        // Mispredict in E, then async reset mid-cycle.
        send_branch(32'h60, 1'b1);
        send_branch(32'h60, 1'b1);
        PCF = 32'h50;
        cyc();
        cyc();
        BranchOpE = 1'b1; PCSrcResE = 1'b1;
        push("misp_same_cycle", ~mdl[m_idx(32'h50)][1]);
        #2;
        pop_check(MispredictE);
        PCF = 32'h60;
        reset = 1'b1;
        #1;
        m_reset();
        push("midrst_predF", 1'b0); pop_check(PCSrcPredF);
        push("midrst_predE", 1'b0); pop_check(PCSrcPredE);
        push("midrst_mispE", 1'b0); pop_check(MispredictE);
        #3;
        reset = 1'b0; BranchOpE = 1'b0;
        cyc();
        check_pc("post_rst_idx", 32'h60);
        send_branch(32'h60, 1'b1);
        check_pc("post_rst_wu_to_wt", 32'h60);

`ifdef GSHARE_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_reset();
        cyc();
        send_branch(32'h40, 1'b1);
        send_branch(32'h40, 1'b1);
        check_pc("gs_idx7_read", 32'h10);
        // Overlap: A is fetched before B updates the history.
        PCF = 32'h40;
        ixb = m_idx(32'h40);
        cyc();
        PCF = 32'h10;
        ixa = m_idx(32'h10);
        cyc();
        BranchOpE = 1'b1; PCSrcResE = 1'b1;
        cyc();
        m_update(ixb, 1'b1);
        cyc();
        BranchOpE = 1'b0;
        m_update(ixa, 1'b1);
        check_pc("gs_upd_stored_idx", XL'(ixa ^ ghr) << 2);
        check_pc("gs_recomputed_idx", XL'((IB'(4) ^ ghr) ^ ghr) << 2);
        check_pc("gs_other_idx3", XL'(IB'(3) ^ ghr) << 2);
`endif

        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
